// File: rtl/cost_request_controller.sv
// Sequences one training sample: label -> confidences -> cost calculator launch -> cost handoff.
// Optional running cost accumulator is enabled by defining COST_ACCUM_EN.
module cost_request_controller #(
    parameter int NUM_DIGITS = 10,
    parameter int CONF_W     = 4,
    parameter int COST_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 label_valid,
    input  logic [3:0]                           label_digit,
    output logic                                 label_ready,
    input  logic                                 conf_valid,
    input  logic [0:NUM_DIGITS-1][CONF_W-1:0]    confidences,
    output logic                                 cost_en,
    output logic [0:NUM_DIGITS-1]                expected_label,
    output logic [0:NUM_DIGITS-1][CONF_W-1:0]    digit_weights,
    input  logic                                 calculation_complete,
    input  logic [COST_W-1:0]                    cost_output,
    output logic                                 cost_valid,
    output logic [COST_W-1:0]                    cost_data,
    input  logic                                 cost_ready,
    output logic                                 label_error,
    output logic                                 timeout_error,
    output logic                                 busy
`ifdef COST_ACCUM_EN
    ,
    input  logic                                 clear_accum,
    output logic [15:0]                          cost_sum,
    output logic [7:0]                           sample_count
`endif
);

    localparam int              CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]      MAX_DIGIT = 4'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CONF,
        LAUNCH,
        WAIT_CALC,
        PRESENT
    } state_e;

    state_e                            r_state;
    state_e                            w_next_state;
    logic [CNT_W-1:0]                  r_count;
    logic [0:NUM_DIGITS-1]             r_expected_label;
    logic [0:NUM_DIGITS-1][CONF_W-1:0] r_digit_weights;
    logic [COST_W-1:0]                 r_cost_data;
    logic                              r_label_error;
    logic                              r_timeout_error;

    logic                              w_accept;
    logic                              w_bad_label;
    logic                              w_latch_conf;
    logic                              w_capture;
    logic                              w_timeout;
    logic [0:NUM_DIGITS-1]             w_onehot;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_bad_label  = 1'b0;
        w_latch_conf = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (label_valid) begin
                    if (label_digit > MAX_DIGIT) begin
                        w_bad_label = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = WAIT_CONF;
                    end
                end
            end
            WAIT_CONF: begin
                if (conf_valid) begin
                    w_latch_conf = 1'b1;
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                w_next_state = WAIT_CALC;
            end
            WAIT_CALC: begin
                // Completion is checked first so it wins over an expiring timeout.
                if (calculation_complete) begin
                    w_capture    = 1'b1;
                    w_next_state = PRESENT;
                end else if (r_count == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            PRESENT: begin
                if (cost_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_onehot[i] = (label_digit == 4'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count          <= '0;
            r_expected_label <= '0;
            r_digit_weights  <= '0;
            r_cost_data      <= '0;
            r_label_error    <= 1'b0;
            r_timeout_error  <= 1'b0;
        end else begin
            r_label_error   <= w_bad_label;
            r_timeout_error <= w_timeout;
            if (w_accept) begin
                r_expected_label <= w_onehot;
            end
            if (w_latch_conf) begin
                r_digit_weights <= confidences;
            end
            if (r_state == LAUNCH) begin
                r_count <= '0;
            end else if (r_state == WAIT_CALC && !calculation_complete && r_count != CNT_LAST) begin
                r_count <= r_count + 1'b1;
            end
            if (w_capture) begin
                r_cost_data <= cost_output;
            end
        end
    end

    assign label_ready    = (r_state == IDLE);
    assign cost_en        = (r_state == LAUNCH);
    assign cost_valid     = (r_state == PRESENT);
    assign busy           = (r_state != IDLE);
    assign expected_label = r_expected_label;
    assign digit_weights  = r_digit_weights;
    assign cost_data      = r_cost_data;
    assign label_error    = r_label_error;
    assign timeout_error  = r_timeout_error;

`ifdef COST_ACCUM_EN
    logic [15:0] r_cost_sum;
    logic [7:0]  r_sample_count;
    logic [16:0] w_sum_ext;

    assign w_sum_ext = {1'b0, r_cost_sum} + 17'(cost_output);

    // Clear outranks a same-cycle capture; both totals saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cost_sum     <= '0;
            r_sample_count <= '0;
        end else if (clear_accum) begin
            r_cost_sum     <= '0;
            r_sample_count <= '0;
        end else if (w_capture) begin
            r_cost_sum <= w_sum_ext[16] ? 16'hFFFF : w_sum_ext[15:0];
            if (r_sample_count != 8'hFF) begin
                r_sample_count <= r_sample_count + 8'd1;
            end
        end
    end

    assign cost_sum     = r_cost_sum;
    assign sample_count = r_sample_count;
`endif

endmodule
